// File: rtl/pipeline_ctrl.sv
// Hazard controller for a 5-stage pipeline: memory freeze, multi-cycle divide wait with
// watchdog, branch flush and load-use interlock, plus stall/flush performance counters.
module pipeline_ctrl #(
    parameter int DIV_TIMEOUT = 40
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ID_RS1,
    input  logic [4:0]  ID_RS2,
    input  logic        ID_USES_RS1,
    input  logic        ID_USES_RS2,
    input  logic        EX_MEM_READ,
    input  logic [4:0]  EX_DEST_REG,
    input  logic        EX_BRANCH_TAKEN,
    input  logic        EX_DIV_START,
    input  logic        DIV_DONE,
    input  logic        DMEM_BUSY,
    output logic        PC_STALL,
    output logic        IF_ID_STALL,
    output logic        ID_EX_STALL,
    output logic        EX_MA_STALL,
    output logic        MA_WB_STALL,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_FLUSH,
    output logic        EX_MA_FLUSH,
    output logic        DIV_ERR,
    output logic [15:0] STALL_CNT,
    output logic [15:0] FLUSH_CNT,
    output logic [1:0]  STATE
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_DIV_WAIT = 2'b01
    } state_t;

    localparam logic [5:0] TMO_LAST = 6'(DIV_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [5:0]  div_cnt_q, div_cnt_d;
    logic        done_pend_q, done_pend_d;
    logic        div_err_q, div_err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic pc_stall, if_id_stall, id_ex_stall, ex_ma_stall, ma_wb_stall;
    logic if_id_flush, id_ex_flush, ex_ma_flush;
    logic load_use, div_done_eff, branch_act;

    assign load_use = EX_MEM_READ && (EX_DEST_REG != 5'd0) &&
                      ((ID_USES_RS1 && (ID_RS1 == EX_DEST_REG)) ||
                       (ID_USES_RS2 && (ID_RS2 == EX_DEST_REG)));
    // A completion seen while memory was busy is honoured on the first free cycle.
    assign div_done_eff = DIV_DONE || done_pend_q;

    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        id_ex_stall = 1'b0;
        ex_ma_stall = 1'b0;
        ma_wb_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_ma_flush = 1'b0;
        branch_act  = 1'b0;
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        done_pend_d = done_pend_q;
        div_err_d   = div_err_q;

        if (DMEM_BUSY) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            ex_ma_stall = 1'b1;
            ma_wb_stall = 1'b1;
            if (state_q == ST_DIV_WAIT && DIV_DONE) done_pend_d = 1'b1;
        end else if (state_q == ST_DIV_WAIT) begin
            if (div_done_eff || div_cnt_q == TMO_LAST) begin
                // Release: result (or watchdog garbage) advances into EX_MA.
                state_d     = ST_RUN;
                done_pend_d = 1'b0;
                if (!div_done_eff) div_err_d = 1'b1;
            end else begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_stall = 1'b1;
                ex_ma_flush = 1'b1;
                if (div_cnt_q != 6'h3F) div_cnt_d = div_cnt_q + 6'd1;
            end
        end else if (EX_DIV_START) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            ex_ma_flush = 1'b1;
            state_d     = ST_DIV_WAIT;
            div_cnt_d   = 6'd0;
            done_pend_d = 1'b0;
        end else if (EX_BRANCH_TAKEN) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            branch_act  = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall && stall_cnt_q != 16'hFFFF)   stall_cnt_d = stall_cnt_q + 16'd1;
        if (branch_act && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_RUN;
            div_cnt_q   <= 6'd0;
            done_pend_q <= 1'b0;
            div_err_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            done_pend_q <= done_pend_d;
            div_err_q   <= div_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Hold/flush controls are forced quiet while reset is asserted.
    assign PC_STALL    = RESET & pc_stall;
    assign IF_ID_STALL = RESET & if_id_stall;
    assign ID_EX_STALL = RESET & id_ex_stall;
    assign EX_MA_STALL = RESET & ex_ma_stall;
    assign MA_WB_STALL = RESET & ma_wb_stall;
    assign IF_ID_FLUSH = RESET & if_id_flush;
    assign ID_EX_FLUSH = RESET & id_ex_flush;
    assign EX_MA_FLUSH = RESET & ex_ma_flush;
    assign DIV_ERR     = div_err_q;
    assign STALL_CNT   = stall_cnt_q;
    assign FLUSH_CNT   = flush_cnt_q;
    assign STATE       = state_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_ctrl;
    localparam int TMO = 40;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [4:0]  ID_RS1, ID_RS2, EX_DEST_REG;
    logic        ID_USES_RS1, ID_USES_RS2, EX_MEM_READ, EX_BRANCH_TAKEN;
    logic        EX_DIV_START, DIV_DONE, DMEM_BUSY;
    logic        PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MA_STALL, MA_WB_STALL;
    logic        IF_ID_FLUSH, ID_EX_FLUSH, EX_MA_FLUSH, DIV_ERR;
    logic [15:0] STALL_CNT, FLUSH_CNT;
    logic [1:0]  STATE;

    int checks = 0;
    int errors = 0;

    // Packed view: {PC, IF_ID, ID_EX, EX_MA, MA_WB stalls, IF_ID, ID_EX, EX_MA flushes}
    wire [7:0] outs = {PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MA_STALL, MA_WB_STALL,
                       IF_ID_FLUSH, ID_EX_FLUSH, EX_MA_FLUSH};

    localparam logic [7:0] O_NONE = 8'h00;
    localparam logic [7:0] O_BUSY = 8'hF8;
    localparam logic [7:0] O_DIV  = 8'hE1;
    localparam logic [7:0] O_BR   = 8'h06;
    localparam logic [7:0] O_LU   = 8'hC2;

    pipeline_ctrl #(.DIV_TIMEOUT(TMO)) dut (
        .CLK(CLK), .RESET(RESET),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
        .EX_MEM_READ(EX_MEM_READ), .EX_DEST_REG(EX_DEST_REG), .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN),
        .EX_DIV_START(EX_DIV_START), .DIV_DONE(DIV_DONE), .DMEM_BUSY(DMEM_BUSY),
        .PC_STALL(PC_STALL), .IF_ID_STALL(IF_ID_STALL), .ID_EX_STALL(ID_EX_STALL),
        .EX_MA_STALL(EX_MA_STALL), .MA_WB_STALL(MA_WB_STALL),
        .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH), .EX_MA_FLUSH(EX_MA_FLUSH),
        .DIV_ERR(DIV_ERR), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: "in a divide", how many stall cycles the divide has cost so far,
    // pending completion, sticky error, and counters as plain integers.
    bit m_div, m_pend, m_err;
    int m_stalled, m_scnt, m_fcnt;
    bit n_div, n_pend, n_err;
    int n_stalled, n_scnt, n_fcnt;

    task automatic model_reset();
        m_div = 0; m_pend = 0; m_err = 0; m_stalled = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic model_eval(output logic [7:0] exp);
        bit lu, done;
        lu = EX_MEM_READ && EX_DEST_REG != 0 &&
             ((ID_USES_RS1 && ID_RS1 == EX_DEST_REG) || (ID_USES_RS2 && ID_RS2 == EX_DEST_REG));
        done = DIV_DONE || m_pend;
        n_div = m_div; n_pend = m_pend; n_err = m_err;
        n_stalled = m_stalled; n_scnt = m_scnt; n_fcnt = m_fcnt;
        exp = O_NONE;
        if (DMEM_BUSY) begin
            exp = O_BUSY;
            if (m_div && DIV_DONE) n_pend = 1;
        end else if (m_div) begin
            if (done || m_stalled == TMO) begin
                n_div = 0; n_pend = 0;
                if (!done) n_err = 1;
            end else begin
                exp = O_DIV;
                n_stalled = m_stalled + 1;
            end
        end else if (EX_DIV_START) begin
            exp = O_DIV; n_div = 1; n_stalled = 1; n_pend = 0;
        end else if (EX_BRANCH_TAKEN) begin
            exp = O_BR;
            if (m_fcnt < 65535) n_fcnt = m_fcnt + 1;
        end else if (lu) begin
            exp = O_LU;
        end
        if (exp[7] && m_scnt < 65535) n_scnt = m_scnt + 1;
    endtask

    task automatic model_commit();
        m_div = n_div; m_pend = n_pend; m_err = n_err;
        m_stalled = n_stalled; m_scnt = n_scnt; m_fcnt = n_fcnt;
    endtask

    task automatic idle();
        ID_RS1 = 0; ID_RS2 = 0; ID_USES_RS1 = 0; ID_USES_RS2 = 0;
        EX_MEM_READ = 0; EX_DEST_REG = 0; EX_BRANCH_TAKEN = 0;
        EX_DIV_START = 0; DIV_DONE = 0; DMEM_BUSY = 0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        RESET = 1'b0;
        repeat (2) step();
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        RESET = 1'b0;
        DMEM_BUSY = 1'b1;
        #1;
        checks++;
        if (outs !== O_NONE) begin errors++; $display("FAIL reset_outs: got %h expected %h", outs, O_NONE); end
        step();
        checks++;
        if (STATE !== 2'b00 || DIV_ERR !== 1'b0 || STALL_CNT !== 16'd0 || FLUSH_CNT !== 16'd0) begin
            errors++;
            $display("FAIL reset_regs: got state=%b err=%b scnt=%0d fcnt=%0d expected 00 0 0 0",
                     STATE, DIV_ERR, STALL_CNT, FLUSH_CNT);
        end
        RESET = 1'b1;
        idle();
    endtask

    task automatic test_load_use();
        apply_reset();
        EX_MEM_READ = 1; EX_DEST_REG = 5; ID_RS2 = 5; ID_USES_RS2 = 1; ID_RS1 = 3; ID_USES_RS1 = 1;
        #1;
        checks++;
        if (outs !== O_LU) begin errors++; $display("FAIL load_use_outs: got %h expected %h", outs, O_LU); end
        step();
        idle();
        #1;
        checks++;
        if (outs !== O_NONE || STALL_CNT !== 16'd1) begin
            errors++;
            $display("FAIL load_use_one_cycle: got outs=%h scnt=%0d expected 00 1", outs, STALL_CNT);
        end
        EX_MEM_READ = 1; EX_DEST_REG = 0; ID_RS2 = 0; ID_USES_RS2 = 1; ID_RS1 = 0; ID_USES_RS1 = 1;
        #1;
        checks++;
        if (outs !== O_NONE) begin errors++; $display("FAIL load_use_r0: got %h expected %h", outs, O_NONE); end
        step();
        idle();
    endtask

    task automatic test_div_done();
        apply_reset();
        EX_DIV_START = 1;
        #1;
        checks++;
        if (outs !== O_DIV) begin errors++; $display("FAIL div_start_outs: got %h expected %h", outs, O_DIV); end
        step();
        EX_DIV_START = 0;
        checks++;
        if (STATE !== 2'b01) begin errors++; $display("FAIL div_enter_state: got %b expected 01", STATE); end
        for (int i = 1; i < 10; i++) begin
            #1;
            checks++;
            if (outs !== O_DIV) begin errors++; $display("FAIL div_wait_outs[%0d]: got %h expected %h", i, outs, O_DIV); end
            step();
        end
        DIV_DONE = 1; EX_DIV_START = 1;
        #1;
        checks++;
        if (outs !== O_NONE) begin errors++; $display("FAIL div_release_outs: got %h expected %h", outs, O_NONE); end
        step();
        idle();
        checks++;
        if (STATE !== 2'b00 || STALL_CNT !== 16'd10 || DIV_ERR !== 1'b0) begin
            errors++;
            $display("FAIL div_release_regs: got state=%b scnt=%0d err=%b expected 00 10 0", STATE, STALL_CNT, DIV_ERR);
        end
        DIV_DONE = 1;
        #1;
        step();
        DIV_DONE = 0;
        checks++;
        if (STATE !== 2'b00 || outs !== O_NONE) begin
            errors++;
            $display("FAIL div_done_in_run: got state=%b outs=%h expected 00 00", STATE, outs);
        end
    endtask

    task automatic test_div_timeout();
        apply_reset();
        EX_DIV_START = 1;
        step();
        EX_DIV_START = 0;
        for (int i = 1; i < TMO; i++) step();
        #1;
        checks++;
        if (outs !== O_NONE || DIV_ERR !== 1'b0) begin
            errors++;
            $display("FAIL timeout_release: got outs=%h err=%b expected 00 0", outs, DIV_ERR);
        end
        step();
        checks++;
        if (DIV_ERR !== 1'b1 || STATE !== 2'b00 || STALL_CNT !== 16'(TMO)) begin
            errors++;
            $display("FAIL timeout_regs: got err=%b state=%b scnt=%0d expected 1 00 %0d", DIV_ERR, STATE, STALL_CNT, TMO);
        end
        EX_DIV_START = 1; step(); EX_DIV_START = 0;
        DIV_DONE = 1; step(); DIV_DONE = 0;
        repeat (3) step();
        checks++;
        if (DIV_ERR !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", DIV_ERR); end
        RESET = 1'b0;
        #1;
        checks++;
        if (DIV_ERR !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", DIV_ERR); end
        step();
        RESET = 1'b1;
    endtask

    task automatic test_dmem_busy_div();
        apply_reset();
        EX_DIV_START = 1; step(); EX_DIV_START = 0;
        repeat (3) step();
        DMEM_BUSY = 1;
        for (int i = 0; i < 3; i++) begin
            DIV_DONE = (i == 1);
            #1;
            checks++;
            if (outs !== O_BUSY || STATE !== 2'b01) begin
                errors++;
                $display("FAIL busy_freeze[%0d]: got outs=%h state=%b expected %h 01", i, outs, STATE, O_BUSY);
            end
            step();
        end
        DMEM_BUSY = 0; DIV_DONE = 0;
        #1;
        checks++;
        if (outs !== O_NONE) begin errors++; $display("FAIL busy_pending_release: got %h expected %h", outs, O_NONE); end
        step();
        checks++;
        if (STATE !== 2'b00 || STALL_CNT !== 16'd7 || DIV_ERR !== 1'b0) begin
            errors++;
            $display("FAIL busy_pending_regs: got state=%b scnt=%0d err=%b expected 00 7 0", STATE, STALL_CNT, DIV_ERR);
        end
    endtask

    task automatic test_branch_loaduse();
        apply_reset();
        EX_BRANCH_TAKEN = 1; EX_MEM_READ = 1; EX_DEST_REG = 7; ID_RS1 = 7; ID_USES_RS1 = 1;
        #1;
        checks++;
        if (outs !== O_BR) begin errors++; $display("FAIL branch_over_lu: got %h expected %h", outs, O_BR); end
        step();
        idle();
        checks++;
        if (FLUSH_CNT !== 16'd1 || STALL_CNT !== 16'd0) begin
            errors++;
            $display("FAIL branch_counts: got fcnt=%0d scnt=%0d expected 1 0", FLUSH_CNT, STALL_CNT);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        EX_DIV_START = 1; step(); EX_DIV_START = 0;
        EX_BRANCH_TAKEN = 1;
        repeat (4) step();
        #2;
        RESET = 1'b0;
        #1;
        checks++;
        if (STATE !== 2'b00 || outs !== O_NONE || STALL_CNT !== 16'd0 || FLUSH_CNT !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: got state=%b outs=%h scnt=%0d fcnt=%0d expected 00 00 0 0",
                     STATE, outs, STALL_CNT, FLUSH_CNT);
        end
        idle();
        step();
        RESET = 1'b1;
    endtask

    task automatic test_random();
        logic [7:0] exp;
        apply_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            DMEM_BUSY       = ($urandom_range(0, 7) == 0);
            EX_DIV_START    = ($urandom_range(0, 9) == 0);
            DIV_DONE        = ($urandom_range(0, 11) == 0);
            EX_BRANCH_TAKEN = ($urandom_range(0, 5) == 0);
            EX_MEM_READ     = $urandom_range(0, 1);
            EX_DEST_REG     = 5'($urandom_range(0, 3));
            ID_RS1          = 5'($urandom_range(0, 3));
            ID_RS2          = 5'($urandom_range(0, 3));
            ID_USES_RS1     = $urandom_range(0, 1);
            ID_USES_RS2     = $urandom_range(0, 1);
            model_eval(exp);
            #1;
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL rand_outs[%0d]: got %h expected %h", c, outs, exp);
            end
            step();
            model_commit();
            checks++;
            if (STATE !== {1'b0, m_div} || DIV_ERR !== m_err ||
                STALL_CNT !== 16'(m_scnt) || FLUSH_CNT !== 16'(m_fcnt)) begin
                errors++;
                $display("FAIL rand_regs[%0d]: got state=%b err=%b scnt=%0d fcnt=%0d expected %b %b %0d %0d",
                         c, STATE, DIV_ERR, STALL_CNT, FLUSH_CNT, {1'b0, m_div}, m_err, m_scnt, m_fcnt);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        RESET = 1'b1;
        #2;
        test_reset();
        test_load_use();
        test_div_done();
        test_div_timeout();
        test_dmem_busy_div();
        test_branch_loaduse();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
